// File: rtl/vid_stream_monitor_if.sv
// vid_stream_monitor_if: snooped AXI4-Stream video handshake (tuser=SOF, tlast=EOL)
interface vid_stream_monitor_if;
    logic tvalid;
    logic tready;
    logic tlast;
    logic tuser;
    modport master (output tvalid, output tlast, output tuser, input tready);
    modport slave (input tvalid, input tready, input tlast, input tuser);
endinterface

// File: rtl/vid_stream_monitor.sv
// vid_stream_monitor: passive AXI4-Stream video frame/line/pixel monitor with framing error flags.
// Define VID_MON_ERR_CNT_EN to implement the per-error counters; otherwise err_cnt reads 0.
module vid_stream_monitor #(
    parameter int MAX_HSIZE = 1920,
    parameter int MAX_VSIZE = 1080,
    parameter int PPC = 1,
    parameter int FRAME_CNT_W = 32,
    parameter int ERR_CNT_W = 16,
    localparam int HW = $clog2(MAX_HSIZE) + 1,
    localparam int VW = $clog2(MAX_VSIZE) + 1
) (
    input  logic                   aclk,
    input  logic                   areset,
    vid_stream_monitor_if.slave    s_axis,
    input  logic [HW-1:0]          exp_hsize,
    input  logic [VW-1:0]          exp_vsize,
    input  logic                   clr_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [VW-1:0]          line_cnt,
    output logic [HW-1:0]          pixel_cnt,
    output logic [HW-1:0]          last_hsize,
    output logic [VW-1:0]          last_vsize,
    output logic                   geom_valid,
    output logic [3:0]             err_flags,
    output logic [4*ERR_CNT_W-1:0] err_cnt
);
    typedef enum logic {WAIT_SOF, ACTIVE} state_t;
    state_t state_q, state_d;
    logic active, beat, sof, run, eol;
    logic [HW:0] np_raw;
    logic [HW-1:0] np;
    logic [VW:0] nl_raw;
    logic [VW-1:0] nl;
    logic eol_late_done, sof_late_done;
    logic [3:0] ev;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= WAIT_SOF;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = sof ? ACTIVE : state_q;
    end

    always_comb begin
        active = state_q == ACTIVE;
    end

    assign beat = s_axis.tvalid & s_axis.tready;
    assign sof = beat & s_axis.tuser;
    assign run = beat & (active | s_axis.tuser);
    assign eol = run & s_axis.tlast;
    // an SOF beat restarts both the line and the frame before adding itself
    assign np_raw = (sof ? '0 : {1'b0, pixel_cnt}) + (HW+1)'(PPC);
    assign np = np_raw[HW] ? '1 : np_raw[HW-1:0];
    assign nl_raw = (sof ? '0 : {1'b0, line_cnt}) + (VW+1)'(1);
    assign nl = nl_raw[VW] ? '1 : nl_raw[VW-1:0];

    assign ev[0] = eol & (exp_hsize != '0) & (np < exp_hsize);
    assign ev[1] = run & ~s_axis.tlast & (exp_hsize != '0) & (np > exp_hsize) & (sof | ~eol_late_done);
    assign ev[2] = sof & active & (exp_vsize != '0) & (line_cnt < exp_vsize);
    assign ev[3] = eol & (exp_vsize != '0) & (nl > exp_vsize) & (sof | ~sof_late_done);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            frame_cnt <= '0;
            line_cnt <= '0;
            pixel_cnt <= '0;
            last_hsize <= '0;
            last_vsize <= '0;
            geom_valid <= 1'b0;
            eol_late_done <= 1'b0;
            sof_late_done <= 1'b0;
        end else if (run) begin
            frame_cnt <= sof ? frame_cnt + FRAME_CNT_W'(1) : frame_cnt;
            line_cnt <= s_axis.tlast ? nl : (sof ? '0 : line_cnt);
            pixel_cnt <= s_axis.tlast ? '0 : np;
            last_hsize <= s_axis.tlast ? np : last_hsize;
            last_vsize <= (sof & active) ? line_cnt : last_vsize;
            geom_valid <= geom_valid | (sof & active);
            eol_late_done <= ~s_axis.tlast & (ev[1] | (~sof & eol_late_done));
            sof_late_done <= ev[3] | (~sof & sof_late_done);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) err_flags <= '0;
        else err_flags <= clr_err ? ev : err_flags | ev;
    end

`ifdef VID_MON_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] cnt_q [4];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                cnt_q[i] <= clr_err ? ERR_CNT_W'(ev[i]) :
                            (ev[i] & ~&cnt_q[i]) ? cnt_q[i] + ERR_CNT_W'(1) : cnt_q[i];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign err_cnt[g*ERR_CNT_W +: ERR_CNT_W] = cnt_q[g];
    end
`else
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_vid_stream_monitor.sv
// tb_vid_stream_monitor: PPC=1 and PPC=2 monitors snoop one bus; checked against a line-level model
module tb_vid_stream_monitor;
    localparam int HW = 12;
    localparam int VW = 12;
    localparam int CW = 16;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic clr_err = 1'b0;
    int eh = 0;
    int ev = 0;
    logic [HW-1:0] exp_h;
    logic [VW-1:0] exp_v;
    logic [31:0] frame_cnt [2];
    logic [VW-1:0] line_cnt [2];
    logic [HW-1:0] pixel_cnt [2];
    logic [HW-1:0] last_hsize [2];
    logic [VW-1:0] last_vsize [2];
    logic geom_valid [2];
    logic [3:0] err_flags [2];
    logic [4*CW-1:0] err_cnt [2];

    int n_tests = 0;
    int n_fail = 0;

    int m_frames [2];
    int m_lines [2];
    int m_lasth [2];
    int m_lastv [2];
    bit m_geom [2];
    bit m_active [2];
    bit m_sld [2];
    int m_cnt [2][4];
    bit m_flg [2][4];

    vid_stream_monitor_if bus ();

    assign exp_h = HW'(eh);
    assign exp_v = VW'(ev);

    always #5 aclk = ~aclk;

    vid_stream_monitor #(.PPC(1)) dut0 (
        .aclk(aclk), .areset(areset), .s_axis(bus), .exp_hsize(exp_h), .exp_vsize(exp_v),
        .clr_err(clr_err), .frame_cnt(frame_cnt[0]), .line_cnt(line_cnt[0]), .pixel_cnt(pixel_cnt[0]),
        .last_hsize(last_hsize[0]), .last_vsize(last_vsize[0]), .geom_valid(geom_valid[0]),
        .err_flags(err_flags[0]), .err_cnt(err_cnt[0])
    );

    vid_stream_monitor #(.PPC(2)) dut1 (
        .aclk(aclk), .areset(areset), .s_axis(bus), .exp_hsize(exp_h), .exp_vsize(exp_v),
        .clr_err(clr_err), .frame_cnt(frame_cnt[1]), .line_cnt(line_cnt[1]), .pixel_cnt(pixel_cnt[1]),
        .last_hsize(last_hsize[1]), .last_vsize(last_vsize[1]), .geom_valid(geom_valid[1]),
        .err_flags(err_flags[1]), .err_cnt(err_cnt[1])
    );

    function automatic logic [4*CW-1:0] exp_ec(input int d);
        logic [4*CW-1:0] r = '0;
`ifdef VID_MON_ERR_CNT_EN
        for (int i = 0; i < 4; i++) r[i*CW +: CW] = CW'(m_cnt[d][i]);
`endif
        return r;
    endfunction

    function automatic logic [3:0] exp_fl(input int d);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = m_flg[d][i];
        return r;
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_frames[d] = 0; m_lines[d] = 0; m_lasth[d] = 0; m_lastv[d] = 0;
            m_geom[d] = 0; m_active[d] = 0; m_sld[d] = 0;
            for (int i = 0; i < 4; i++) begin m_cnt[d][i] = 0; m_flg[d][i] = 0; end
        end
    endtask

    task automatic m_event(input int d, input int i);
        m_flg[d][i] = 1;
        m_cnt[d][i]++;
    endtask

    task automatic m_clear(input int d);
        for (int i = 0; i < 4; i++) begin m_cnt[d][i] = 0; m_flg[d][i] = 0; end
    endtask

    task automatic put(input bit v, input bit r, input bit u, input bit l, input bit c);
        @(negedge aclk);
        bus.tvalid = v; bus.tready = r; bus.tuser = u; bus.tlast = l; clr_err = c;
    endtask

    task automatic idle();
        put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic stall(input int gap);
        bit v;
        if (gap == 1) put(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
        else if (gap == 2) repeat ($urandom_range(0, 2)) begin
            v = 1'($urandom);
            put(v, v ? 1'b0 : 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    // one complete line of 'beats' beats; the model works on whole lines, not beats
    task automatic send_line(input int beats, input bit sof, input bit clr_last, input int gap);
        int ppc;
        for (int k = 0; k < beats; k++) begin
            stall(gap);
            put(1'b1, 1'b1, sof && k == 0, k == beats - 1, clr_last && k == beats - 1);
        end
        for (int d = 0; d < 2; d++) begin
            ppc = d == 0 ? 1 : 2;
            if (sof) begin
                if (m_active[d]) begin
                    if (ev != 0 && m_lines[d] < ev) m_event(d, 2);
                    m_lastv[d] = m_lines[d];
                    m_geom[d] = 1;
                end
                m_frames[d]++; m_lines[d] = 0; m_active[d] = 1; m_sld[d] = 0;
            end
            if (m_active[d]) begin
                if (eh != 0 && (beats - 1) * ppc > eh) m_event(d, 1);
                if (clr_last) m_clear(d);
                if (eh != 0 && beats * ppc < eh) m_event(d, 0);
                m_lines[d]++;
                m_lasth[d] = beats * ppc;
                if (ev != 0 && m_lines[d] > ev && !m_sld[d]) begin m_event(d, 3); m_sld[d] = 1; end
            end else if (clr_last) m_clear(d);
        end
    endtask

    task automatic send_frame(input int nlines, input int len, input int gap);
        for (int l = 0; l < nlines; l++) send_line(len, l == 0, 1'b0, gap);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1; bus.tvalid = 1'b0; bus.tready = 1'b0; bus.tuser = 1'b0; bus.tlast = 1'b0; clr_err = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        string nm = "reset";
        bus.tvalid = 1'b1; bus.tready = 1'b1; bus.tuser = 1'b1; bus.tlast = 1'b0;
        eh = 8; ev = 4;
        m_reset();
        repeat (3) @(negedge aclk);
        for (int d = 0; d < 2; d++) begin
            n_tests += 8;
            if (frame_cnt[d] !== 32'(m_frames[d])) begin n_fail++; $display("FAIL %s dut%0d frame_cnt got %0d want %0d", nm, d, frame_cnt[d], m_frames[d]); end
            if (line_cnt[d] !== VW'(m_lines[d])) begin n_fail++; $display("FAIL %s dut%0d line_cnt got %0d want %0d", nm, d, line_cnt[d], m_lines[d]); end
            if (pixel_cnt[d] !== '0) begin n_fail++; $display("FAIL %s dut%0d pixel_cnt got %0d want 0", nm, d, pixel_cnt[d]); end
            if (last_hsize[d] !== HW'(m_lasth[d])) begin n_fail++; $display("FAIL %s dut%0d last_hsize got %0d want %0d", nm, d, last_hsize[d], m_lasth[d]); end
            if (last_vsize[d] !== VW'(m_lastv[d])) begin n_fail++; $display("FAIL %s dut%0d last_vsize got %0d want %0d", nm, d, last_vsize[d], m_lastv[d]); end
            if (geom_valid[d] !== m_geom[d]) begin n_fail++; $display("FAIL %s dut%0d geom_valid got %0b want %0b", nm, d, geom_valid[d], m_geom[d]); end
            if (err_flags[d] !== exp_fl(d)) begin n_fail++; $display("FAIL %s dut%0d err_flags got %b want %b", nm, d, err_flags[d], exp_fl(d)); end
            if (err_cnt[d] !== exp_ec(d)) begin n_fail++; $display("FAIL %s dut%0d err_cnt got %h want %h", nm, d, err_cnt[d], exp_ec(d)); end
        end
    endtask

    task automatic test_clean_frames();
        string nm = "clean_frames";
        do_reset();
        eh = 8; ev = 4;
        repeat (3) send_frame(4, 8, 0);
        idle();
        n_tests += 5;
        if (frame_cnt[0] !== 32'd3) begin n_fail++; $display("FAIL %s dut0 frame_cnt got %0d want 3", nm, frame_cnt[0]); end
        if (last_hsize[0] !== 12'd8) begin n_fail++; $display("FAIL %s dut0 last_hsize got %0d want 8", nm, last_hsize[0]); end
        if (last_vsize[0] !== 12'd4) begin n_fail++; $display("FAIL %s dut0 last_vsize got %0d want 4", nm, last_vsize[0]); end
        if (geom_valid[0] !== 1'b1) begin n_fail++; $display("FAIL %s dut0 geom_valid got %0b want 1", nm, geom_valid[0]); end
        if (err_flags[0] !== 4'b0) begin n_fail++; $display("FAIL %s dut0 err_flags got %b want 0000", nm, err_flags[0]); end
        for (int d = 0; d < 2; d++) begin
            n_tests += 6;
            if (frame_cnt[d] !== 32'(m_frames[d])) begin n_fail++; $display("FAIL %s dut%0d frame_cnt got %0d want %0d", nm, d, frame_cnt[d], m_frames[d]); end
            if (line_cnt[d] !== VW'(m_lines[d])) begin n_fail++; $display("FAIL %s dut%0d line_cnt got %0d want %0d", nm, d, line_cnt[d], m_lines[d]); end
            if (last_hsize[d] !== HW'(m_lasth[d])) begin n_fail++; $display("FAIL %s dut%0d last_hsize got %0d want %0d", nm, d, last_hsize[d], m_lasth[d]); end
            if (last_vsize[d] !== VW'(m_lastv[d])) begin n_fail++; $display("FAIL %s dut%0d last_vsize got %0d want %0d", nm, d, last_vsize[d], m_lastv[d]); end
            if (err_flags[d] !== exp_fl(d)) begin n_fail++; $display("FAIL %s dut%0d err_flags got %b want %b", nm, d, err_flags[d], exp_fl(d)); end
            if (err_cnt[d] !== exp_ec(d)) begin n_fail++; $display("FAIL %s dut%0d err_cnt got %h want %h", nm, d, err_cnt[d], exp_ec(d)); end
        end
    endtask

    task automatic test_eol_early();
        string nm = "eol_early";
        do_reset();
        eh = 8; ev = 0;
        send_line(3, 1'b1, 1'b0, 0);
        idle();
        n_tests += 2;
        if (last_hsize[1] !== 12'd6) begin n_fail++; $display("FAIL %s dut1 last_hsize got %0d want 6", nm, last_hsize[1]); end
        if (err_flags[1][0] !== 1'b1) begin n_fail++; $display("FAIL %s dut1 eol_early got %0b want 1", nm, err_flags[1][0]); end
        for (int d = 0; d < 2; d++) begin
            n_tests += 4;
            if (pixel_cnt[d] !== '0) begin n_fail++; $display("FAIL %s dut%0d pixel_cnt got %0d want 0", nm, d, pixel_cnt[d]); end
            if (last_hsize[d] !== HW'(m_lasth[d])) begin n_fail++; $display("FAIL %s dut%0d last_hsize got %0d want %0d", nm, d, last_hsize[d], m_lasth[d]); end
            if (err_flags[d] !== exp_fl(d)) begin n_fail++; $display("FAIL %s dut%0d err_flags got %b want %b", nm, d, err_flags[d], exp_fl(d)); end
            if (err_cnt[d] !== exp_ec(d)) begin n_fail++; $display("FAIL %s dut%0d err_cnt got %h want %h", nm, d, err_cnt[d], exp_ec(d)); end
        end
    endtask

    task automatic test_eol_late();
        string nm = "eol_late";
        do_reset();
        eh = 8; ev = 0;
        for (int k = 0; k < 12; k++) put(1'b1, 1'b1, k == 0, 1'b0, 1'b0);
        idle();
        n_tests += 2;
        if (pixel_cnt[0] !== 12'd12) begin n_fail++; $display("FAIL %s dut0 pixel_cnt got %0d want 12", nm, pixel_cnt[0]); end
        if (pixel_cnt[1] !== 12'd24) begin n_fail++; $display("FAIL %s dut1 pixel_cnt got %0d want 24", nm, pixel_cnt[1]); end
        put(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        for (int d = 0; d < 2; d++) begin
            m_frames[d] = 1; m_active[d] = 1; m_lines[d] = 1;
            m_lasth[d] = 13 * (d + 1);
            m_event(d, 1);
        end
        n_tests += 1;
        if (last_hsize[0] !== 12'd13) begin n_fail++; $display("FAIL %s dut0 last_hsize got %0d want 13", nm, last_hsize[0]); end
        for (int d = 0; d < 2; d++) begin
            n_tests += 4;
            if (last_hsize[d] !== HW'(m_lasth[d])) begin n_fail++; $display("FAIL %s dut%0d last_hsize got %0d want %0d", nm, d, last_hsize[d], m_lasth[d]); end
            if (line_cnt[d] !== VW'(m_lines[d])) begin n_fail++; $display("FAIL %s dut%0d line_cnt got %0d want %0d", nm, d, line_cnt[d], m_lines[d]); end
            if (err_flags[d] !== exp_fl(d)) begin n_fail++; $display("FAIL %s dut%0d err_flags got %b want %b", nm, d, err_flags[d], exp_fl(d)); end
            if (err_cnt[d] !== exp_ec(d)) begin n_fail++; $display("FAIL %s dut%0d err_cnt got %h want %h", nm, d, err_cnt[d], exp_ec(d)); end
        end
    endtask

    task automatic test_sof_errors();
        string nm = "sof_errors";
        do_reset();
        eh = 0; ev = 4;
        send_frame(2, 4, 0);
        send_frame(6, 4, 0);
        idle();
        n_tests += 2;
        if (last_vsize[0] !== 12'd2) begin n_fail++; $display("FAIL %s dut0 last_vsize got %0d want 2", nm, last_vsize[0]); end
        if (err_flags[0] !== 4'b1100) begin n_fail++; $display("FAIL %s dut0 err_flags got %b want 1100", nm, err_flags[0]); end
        send_frame(4, 4, 0);
        idle();
        for (int d = 0; d < 2; d++) begin
            n_tests += 5;
            if (frame_cnt[d] !== 32'(m_frames[d])) begin n_fail++; $display("FAIL %s dut%0d frame_cnt got %0d want %0d", nm, d, frame_cnt[d], m_frames[d]); end
            if (last_vsize[d] !== VW'(m_lastv[d])) begin n_fail++; $display("FAIL %s dut%0d last_vsize got %0d want %0d", nm, d, last_vsize[d], m_lastv[d]); end
            if (geom_valid[d] !== m_geom[d]) begin n_fail++; $display("FAIL %s dut%0d geom_valid got %0b want %0b", nm, d, geom_valid[d], m_geom[d]); end
            if (err_flags[d] !== exp_fl(d)) begin n_fail++; $display("FAIL %s dut%0d err_flags got %b want %b", nm, d, err_flags[d], exp_fl(d)); end
            if (err_cnt[d] !== exp_ec(d)) begin n_fail++; $display("FAIL %s dut%0d err_cnt got %h want %h", nm, d, err_cnt[d], exp_ec(d)); end
        end
    endtask

    task automatic test_back_to_back();
        string nm = "back_to_back";
        do_reset();
        eh = 8; ev = 4;
        send_line(5, 1'b0, 1'b0, 1);
        send_line(3, 1'b0, 1'b0, 1);
        idle();
        n_tests += 3;
        if (frame_cnt[0] !== 32'd0) begin n_fail++; $display("FAIL %s dut0 pre-SOF frame_cnt got %0d want 0", nm, frame_cnt[0]); end
        if (pixel_cnt[0] !== 12'd0) begin n_fail++; $display("FAIL %s dut0 pre-SOF pixel_cnt got %0d want 0", nm, pixel_cnt[0]); end
        if (err_flags[0] !== 4'b0) begin n_fail++; $display("FAIL %s dut0 pre-SOF err_flags got %b want 0000", nm, err_flags[0]); end
        repeat (3) send_frame(4, 8, 1);
        idle();
        for (int d = 0; d < 2; d++) begin
            n_tests += 7;
            if (frame_cnt[d] !== 32'(m_frames[d])) begin n_fail++; $display("FAIL %s dut%0d frame_cnt got %0d want %0d", nm, d, frame_cnt[d], m_frames[d]); end
            if (line_cnt[d] !== VW'(m_lines[d])) begin n_fail++; $display("FAIL %s dut%0d line_cnt got %0d want %0d", nm, d, line_cnt[d], m_lines[d]); end
            if (last_hsize[d] !== HW'(m_lasth[d])) begin n_fail++; $display("FAIL %s dut%0d last_hsize got %0d want %0d", nm, d, last_hsize[d], m_lasth[d]); end
            if (last_vsize[d] !== VW'(m_lastv[d])) begin n_fail++; $display("FAIL %s dut%0d last_vsize got %0d want %0d", nm, d, last_vsize[d], m_lastv[d]); end
            if (geom_valid[d] !== m_geom[d]) begin n_fail++; $display("FAIL %s dut%0d geom_valid got %0b want %0b", nm, d, geom_valid[d], m_geom[d]); end
            if (err_flags[d] !== exp_fl(d)) begin n_fail++; $display("FAIL %s dut%0d err_flags got %b want %b", nm, d, err_flags[d], exp_fl(d)); end
            if (err_cnt[d] !== exp_ec(d)) begin n_fail++; $display("FAIL %s dut%0d err_cnt got %h want %h", nm, d, err_cnt[d], exp_ec(d)); end
        end
    endtask

    task automatic test_async_reset_clr();
        string nm = "async_reset";
        do_reset();
        eh = 8; ev = 4;
        send_frame(2, 5, 0);
        for (int k = 0; k < 3; k++) put(1'b1, 1'b1, k == 0, 1'b0, 1'b0);
        @(negedge aclk);
        #2 areset = 1'b1;
        #1 m_reset();
        for (int d = 0; d < 2; d++) begin
            n_tests += 7;
            if (frame_cnt[d] !== '0) begin n_fail++; $display("FAIL %s dut%0d frame_cnt got %0d want 0", nm, d, frame_cnt[d]); end
            if (line_cnt[d] !== '0) begin n_fail++; $display("FAIL %s dut%0d line_cnt got %0d want 0", nm, d, line_cnt[d]); end
            if (pixel_cnt[d] !== '0) begin n_fail++; $display("FAIL %s dut%0d pixel_cnt got %0d want 0", nm, d, pixel_cnt[d]); end
            if (last_hsize[d] !== '0) begin n_fail++; $display("FAIL %s dut%0d last_hsize got %0d want 0", nm, d, last_hsize[d]); end
            if (last_vsize[d] !== '0) begin n_fail++; $display("FAIL %s dut%0d last_vsize got %0d want 0", nm, d, last_vsize[d]); end
            if (geom_valid[d] !== 1'b0) begin n_fail++; $display("FAIL %s dut%0d geom_valid got %0b want 0", nm, d, geom_valid[d]); end
            if (err_flags[d] !== 4'b0) begin n_fail++; $display("FAIL %s dut%0d err_flags got %b want 0000", nm, d, err_flags[d]); end
        end
        @(negedge aclk);
        areset = 1'b0; bus.tvalid = 1'b0; bus.tready = 1'b0;
        send_line(4, 1'b0, 1'b0, 0);
        send_line(2, 1'b0, 1'b0, 0);
        idle();
        for (int d = 0; d < 2; d++) begin
            n_tests += 3;
            if (frame_cnt[d] !== '0) begin n_fail++; $display("FAIL %s dut%0d resync frame_cnt got %0d want 0", nm, d, frame_cnt[d]); end
            if (line_cnt[d] !== '0) begin n_fail++; $display("FAIL %s dut%0d resync line_cnt got %0d want 0", nm, d, line_cnt[d]); end
            if (last_hsize[d] !== '0) begin n_fail++; $display("FAIL %s dut%0d resync last_hsize got %0d want 0", nm, d, last_hsize[d]); end
        end
        nm = "clr_coincident";
        ev = 0;
        send_line(3, 1'b1, 1'b0, 0);
        send_line(3, 1'b0, 1'b1, 0);
        idle();
        for (int d = 0; d < 2; d++) begin
            n_tests += 3;
            if (err_flags[d] !== 4'b0001) begin n_fail++; $display("FAIL %s dut%0d err_flags got %b want 0001", nm, d, err_flags[d]); end
            if (err_flags[d] !== exp_fl(d)) begin n_fail++; $display("FAIL %s dut%0d model err_flags got %b want %b", nm, d, err_flags[d], exp_fl(d)); end
            if (err_cnt[d] !== exp_ec(d)) begin n_fail++; $display("FAIL %s dut%0d err_cnt got %h want %h", nm, d, err_cnt[d], exp_ec(d)); end
        end
        nm = "clr_alone";
        put(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        for (int d = 0; d < 2; d++) begin
            m_clear(d);
            n_tests += 2;
            if (err_flags[d] !== exp_fl(d)) begin n_fail++; $display("FAIL %s dut%0d err_flags got %b want %b", nm, d, err_flags[d], exp_fl(d)); end
            if (err_cnt[d] !== exp_ec(d)) begin n_fail++; $display("FAIL %s dut%0d err_cnt got %h want %h", nm, d, err_cnt[d], exp_ec(d)); end
        end
    endtask

    task automatic test_random();
        string nm = "random";
        int nf, nl, len;
        bit c;
        for (int it = 0; it < 5; it++) begin
            do_reset();
            eh = $urandom_range(4, 12);
            ev = $urandom_range(2, 5);
            nf = $urandom_range(3, 5);
            for (int f = 0; f < nf; f++) begin
                nl = $urandom_range(1, 7);
                for (int l = 0; l < nl; l++) begin
                    len = $urandom_range(1, 12);
                    c = len > 1 && $urandom_range(0, 7) == 0;
                    send_line(len, l == 0, c, 2);
                end
            end
            idle();
            for (int d = 0; d < 2; d++) begin
                n_tests += 8;
                if (frame_cnt[d] !== 32'(m_frames[d])) begin n_fail++; $display("FAIL %s%0d dut%0d frame_cnt got %0d want %0d", nm, it, d, frame_cnt[d], m_frames[d]); end
                if (line_cnt[d] !== VW'(m_lines[d])) begin n_fail++; $display("FAIL %s%0d dut%0d line_cnt got %0d want %0d", nm, it, d, line_cnt[d], m_lines[d]); end
                if (pixel_cnt[d] !== '0) begin n_fail++; $display("FAIL %s%0d dut%0d pixel_cnt got %0d want 0", nm, it, d, pixel_cnt[d]); end
                if (last_hsize[d] !== HW'(m_lasth[d])) begin n_fail++; $display("FAIL %s%0d dut%0d last_hsize got %0d want %0d", nm, it, d, last_hsize[d], m_lasth[d]); end
                if (last_vsize[d] !== VW'(m_lastv[d])) begin n_fail++; $display("FAIL %s%0d dut%0d last_vsize got %0d want %0d", nm, it, d, last_vsize[d], m_lastv[d]); end
                if (geom_valid[d] !== m_geom[d]) begin n_fail++; $display("FAIL %s%0d dut%0d geom_valid got %0b want %0b", nm, it, d, geom_valid[d], m_geom[d]); end
                if (err_flags[d] !== exp_fl(d)) begin n_fail++; $display("FAIL %s%0d dut%0d err_flags got %b want %b", nm, it, d, err_flags[d], exp_fl(d)); end
                if (err_cnt[d] !== exp_ec(d)) begin n_fail++; $display("FAIL %s%0d dut%0d err_cnt got %h want %h", nm, it, d, err_cnt[d], exp_ec(d)); end
            end
        end
    endtask

    initial begin
        bus.tvalid = 1'b0; bus.tready = 1'b0; bus.tuser = 1'b0; bus.tlast = 1'b0;
        test_reset();
        test_clean_frames();
        test_eol_early();
        test_eol_late();
        test_sof_errors();
        test_back_to_back();
        test_async_reset_clr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
